// File: rtl/dog_diff_engine.sv
// Purpose: difference-of-Gaussians stage; NUM_SCALES planes in, NUM_SCALES-1 adjacent-scale difference lanes out.
// Latency: one register stage from a read-return beat to the output FIFO; the FIFO is show-ahead.
// Backpressure: reads are limited to FIFO_DEPTH outstanding, so wr_ready_i stalls can never overflow the FIFO.
// Ports: clk/rst (async, active-high); start, mode_i, thresh_i control a frame;
//        rd_valid_o/rd_addr_o issue shared reads, rd_valid_in/rd_data_in return per-plane data;
//        wr_valid_o/wr_ready_i/wr_addr_o/wr_data_o write results; feat_cnt_o, busy_o, err_o, done report status.
module dog_diff_engine #(
    parameter int NUM_SCALES = 3,
    parameter int DW         = 8,
    parameter int AW         = 16,
    parameter int NPIX       = 4096,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode_i,
    input  logic [DW-1:0]                thresh_i,
    output logic                         rd_valid_o,
    output logic [AW-1:0]                rd_addr_o,
    input  logic [NUM_SCALES-1:0]        rd_valid_in,
    input  logic [NUM_SCALES*DW-1:0]     rd_data_in,
    output logic                         wr_valid_o,
    input  logic                         wr_ready_i,
    output logic [AW-1:0]                wr_addr_o,
    output logic [(NUM_SCALES-1)*DW-1:0] wr_data_o,
    output logic [AW:0]                  feat_cnt_o,
    output logic                         busy_o,
    output logic                         err_o,
    output logic                         done
);
    localparam int NL = NUM_SCALES - 1;
    localparam int LW = NL * DW;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW:0]         LP_LAST  = (AW+1)'(NPIX - 1);
    localparam logic [CW-1:0]       LP_DEPTH = CW'(FIFO_DEPTH);
    localparam logic signed [DW:0]  LP_SMAX  = (DW+1)'((1 << (DW-1)) - 1);
    localparam logic signed [DW:0]  LP_SMIN  = ~LP_SMAX;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    logic [AW:0]     r_issued;
    logic [CW-1:0]   r_outst;
    logic [AW-1:0]   r_wr_addr;
    logic [AW:0]     r_feat;
    logic            r_err;
    logic [1:0]      r_mode;
    logic [DW-1:0]   r_thresh;
    logic            r_pipe_vld;
    logic [LW-1:0]   r_pipe_dat;
    logic            r_pipe_feat;
    logic [LW-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;

    logic            w_req;
    logic            w_pop;
    logic            w_push;
    logic            w_beat;
    logic            w_beat_ok;
    logic            w_start;
    logic [LW-1:0]   w_lane_dat;
    logic            w_feat;

    function automatic logic signed [DW:0] f_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [DW:0] r;
        r = $signed({1'b0, a}) - $signed({1'b0, b});
        return r;
    endfunction

    // |d| of a DW+1 signed difference of unsigned DW values always fits in DW bits.
    function automatic logic [DW-1:0] f_abs(input logic signed [DW:0] d);
        logic signed [DW:0] m;
        m = d[DW] ? -d : d;
        return m[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] f_map(input logic signed [DW:0] d, input logic [1:0] mode);
        logic [DW-1:0] r;
        case (mode)
            2'd1: begin
                if (d > LP_SMAX)      r = LP_SMAX[DW-1:0];
                else if (d < LP_SMIN) r = LP_SMIN[DW-1:0];
                else                  r = d[DW-1:0];
            end
            2'd2:    r = d[DW] ? '0 : d[DW-1:0];
            default: r = f_abs(d);
        endcase
        return r;
    endfunction

    always_comb begin
        w_lane_dat = '0;
        w_feat     = 1'b0;
        for (int k = 0; k < NL; k++) begin
            w_lane_dat[k*DW +: DW] = f_map(f_diff(rd_data_in[k*DW +: DW], rd_data_in[(k+1)*DW +: DW]), r_mode);
            if (f_abs(f_diff(rd_data_in[k*DW +: DW], rd_data_in[(k+1)*DW +: DW])) >= r_thresh)
                w_feat = 1'b1;
        end
    end

    // Outstanding covers in-flight reads, the pipeline register and FIFO contents,
    // so a request is only issued when a FIFO slot is guaranteed for its beat.
    assign w_req      = (r_state == S_RUN) && (r_issued <= LP_LAST) && (r_outst < LP_DEPTH);
    assign w_pop      = wr_valid_o && wr_ready_i;
    assign w_beat     = |rd_valid_in;
    assign w_beat_ok  = w_beat && (r_state != S_IDLE) && (r_outst != '0);
    assign w_start    = start && (r_state == S_IDLE);
    // Full-FIFO guard only matters after a protocol error injected a surplus beat.
    assign w_push     = r_pipe_vld && ((r_cnt != LP_DEPTH) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_issued    <= '0;
            r_outst     <= '0;
            r_wr_addr   <= '0;
            r_feat      <= '0;
            r_err       <= 1'b0;
            r_mode      <= '0;
            r_thresh    <= '0;
            r_pipe_vld  <= 1'b0;
            r_pipe_dat  <= '0;
            r_pipe_feat <= 1'b0;
        end else begin
            r_pipe_vld  <= w_beat_ok;
            r_pipe_dat  <= w_lane_dat;
            r_pipe_feat <= w_feat;
            if (w_start) begin
                r_state   <= S_RUN;
                r_issued  <= '0;
                r_outst   <= '0;
                r_wr_addr <= '0;
                r_feat    <= '0;
                r_err     <= 1'b0;
                r_mode    <= mode_i;
                r_thresh  <= thresh_i;
            end else begin
                if (w_req)
                    r_issued <= r_issued + 1'b1;
                r_outst <= r_outst + CW'(w_req) - CW'(w_pop);
                if (w_pop)
                    r_wr_addr <= r_wr_addr + 1'b1;
                if (w_push && r_pipe_feat)
                    r_feat <= r_feat + 1'b1;
                // Partial-valid beats are still processed; unexpected beats are dropped.
                if (w_beat && !(w_beat_ok && (&rd_valid_in)))
                    r_err <= 1'b1;
                case (r_state)
                    S_RUN:   if (w_req && (r_issued == LP_LAST)) r_state <= S_DRAIN;
                    S_DRAIN: if (w_pop && ({1'b0, r_wr_addr} == LP_LAST)) r_state <= S_DONE;
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= r_pipe_dat;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    assign rd_valid_o = w_req;
    assign rd_addr_o  = r_issued[AW-1:0];
    assign wr_valid_o = (r_cnt != '0);
    assign wr_data_o  = r_mem[r_rp];
    assign wr_addr_o  = r_wr_addr;
    assign feat_cnt_o = r_feat;
    assign busy_o     = (r_state != S_IDLE);
    assign err_o      = r_err;
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_dog_diff_engine.sv
// Bench for dog_diff_engine: a 3-plane, 16-pixel instance with a variable-latency RAM model,
// plus a 2-plane, 1-pixel instance with a 2-entry FIFO under random write backpressure.
module tb_dog_diff_engine;
    localparam int NS = 3;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int NP = 16;
    localparam int FD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- instance A ----------------
    logic                   start    = 1'b0;
    logic [1:0]             mode_i   = 2'd0;
    logic [DW-1:0]          thresh_i = '0;
    logic                   rd_valid_o;
    logic [AW-1:0]          rd_addr_o;
    logic [NS-1:0]          rd_valid_in;
    logic [NS*DW-1:0]       rd_data_in;
    logic                   wr_valid_o;
    logic                   wr_ready_i = 1'b0;
    logic [AW-1:0]          wr_addr_o;
    logic [(NS-1)*DW-1:0]   wr_data_o;
    logic [AW:0]            feat_cnt_o;
    logic                   busy_o, err_o, done;

    dog_diff_engine #(.NUM_SCALES(NS), .DW(DW), .AW(AW), .NPIX(NP), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_i(mode_i), .thresh_i(thresh_i),
        .rd_valid_o(rd_valid_o), .rd_addr_o(rd_addr_o), .rd_valid_in(rd_valid_in), .rd_data_in(rd_data_in),
        .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .feat_cnt_o(feat_cnt_o), .busy_o(busy_o), .err_o(err_o), .done(done)
    );

    // RAM model: fixed latency `lat`, planes in pl[], optional corrupted valid mask on one beat.
    logic [7:0]  pl [3][NP];
    logic        sh_v [8];
    logic [15:0] sh_a [8];
    int          lat      = 2;
    int          ret_cnt  = 0;
    int          bad_beat = -1;
    logic [2:0]  bad_mask = 3'b011;
    logic        spur     = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                sh_v[i] <= 1'b0;
                sh_a[i] <= '0;
            end
        end else begin
            sh_v[0] <= rd_valid_o;
            sh_a[0] <= rd_addr_o;
            for (int i = 1; i < 8; i++) begin
                sh_v[i] <= sh_v[i-1];
                sh_a[i] <= sh_a[i-1];
            end
            if (sh_v[lat-1]) ret_cnt <= ret_cnt + 1;
        end
    end

    always_comb begin
        logic [3:0] idx;
        idx         = sh_a[lat-1][3:0];
        rd_valid_in = 3'b000;
        if (spur)
            rd_valid_in = 3'b111;
        else if (sh_v[lat-1])
            rd_valid_in = (ret_cnt == bad_beat) ? bad_mask : 3'b111;
        rd_data_in = {pl[2][idx], pl[1][idx], pl[0][idx]};
    end

    int rdy_mode = 1;   // 0 = low, 1 = high, 2 = random
    always @(posedge clk) begin
        #1;
        wr_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    // Monitor (negedge): write capture, request/pop accounting, done timing, stall stability.
    logic [AW-1:0] q_addr [$];
    logic [15:0]   q_dat  [$];
    int   reqs = 0, pops = 0, max_out = 0, done_cnt = 0, done_cyc = 0, last_hs = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_dat   = '0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (wr_valid_o !== 1'b1 || wr_data_o !== prev_dat || wr_addr_o !== prev_addr) begin
                    n_fail++;
                    $display("FAIL stall_stable: got valid=%b data=%h addr=%0d, expected valid=1 data=%h addr=%0d",
                             wr_valid_o, wr_data_o, wr_addr_o, prev_dat, prev_addr);
                end
            end
            prev_stall = wr_valid_o && !wr_ready_i;
            prev_dat   = wr_data_o;
            prev_addr  = wr_addr_o;
            if (rd_valid_o) reqs++;
            if (wr_valid_o && wr_ready_i) begin
                q_addr.push_back(wr_addr_o);
                q_dat.push_back(wr_data_o);
                pops++;
                last_hs = cyc;
            end
            if (reqs - pops > max_out) max_out = reqs - pops;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- instance B (NPIX=1, FIFO_DEPTH=2) ----------------
    logic        b_start = 1'b0;
    logic        b_rd_valid_o;
    logic [3:0]  b_rd_addr_o;
    logic [1:0]  b_rd_valid_in;
    logic [15:0] b_rd_data_in;
    logic        b_wr_valid_o;
    logic        b_wr_ready_i = 1'b0;
    logic [3:0]  b_wr_addr_o;
    logic [7:0]  b_wr_data_o;
    logic [4:0]  b_feat_cnt_o;
    logic        b_busy_o, b_err_o, b_done;
    logic        b_rv = 1'b0;
    logic [7:0]  b_p0 = 8'd0, b_p1 = 8'd0;

    dog_diff_engine #(.NUM_SCALES(2), .DW(8), .AW(4), .NPIX(1), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .mode_i(2'd0), .thresh_i(8'd0),
        .rd_valid_o(b_rd_valid_o), .rd_addr_o(b_rd_addr_o), .rd_valid_in(b_rd_valid_in), .rd_data_in(b_rd_data_in),
        .wr_valid_o(b_wr_valid_o), .wr_ready_i(b_wr_ready_i), .wr_addr_o(b_wr_addr_o), .wr_data_o(b_wr_data_o),
        .feat_cnt_o(b_feat_cnt_o), .busy_o(b_busy_o), .err_o(b_err_o), .done(b_done)
    );

    always @(posedge clk) b_rv <= rst ? 1'b0 : b_rd_valid_o;
    assign b_rd_valid_in = {2{b_rv}};
    assign b_rd_data_in  = {b_p1, b_p0};

    always @(posedge clk) begin
        #1;
        b_wr_ready_i = 1'($urandom_range(0, 1));
    end

    int         b_writes = 0, b_done_cnt = 0;
    logic [3:0] b_last_addr = '0;
    logic [7:0] b_last_dat  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (b_wr_valid_o && b_wr_ready_i) begin
                b_writes++;
                b_last_addr = b_wr_addr_o;
                b_last_dat  = b_wr_data_o;
            end
            if (b_done) b_done_cnt++;
        end
    end

    // ---------------- reference model ----------------
    function automatic int exp_lane(input int a, input int b, input int m);
        int d;
        d = a - b;
        if (m == 1) begin
            if (d > 127)  d = 127;
            if (d < -128) d = -128;
            return d & 255;
        end
        if (m == 2) return (d < 0) ? 0 : d;
        return (d < 0) ? -d : d;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic fill_const(input int a, input int b, input int c);
        for (int i = 0; i < NP; i++) begin
            pl[0][i] = 8'(a);
            pl[1][i] = 8'(b);
            pl[2][i] = 8'(c);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NP; i++)
            for (int k = 0; k < 3; k++)
                pl[k][i] = 8'($urandom_range(0, 255));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Runs one frame on instance A and checks every write, the feature count and done.
    task automatic run_frame(input string nm, input int m, input int thr, input int latv, input int rdy,
                             input bit stall, input int bad_rel, input bit extra_start, input bit exp_err);
        int base_done;
        int exp_feat;
        logic [15:0] e;
        lat = latv;
        q_addr.delete();
        q_dat.delete();
        reqs = 0; pops = 0; max_out = 0;
        base_done = done_cnt;
        rdy_mode  = stall ? 0 : rdy;
        mode_i    = 2'(m);
        thresh_i  = 8'(thr);
        bad_beat  = (bad_rel >= 0) ? ret_cnt + bad_rel : -1;
        pulse_start();
        // Inputs are sampled at start only; scramble them afterwards.
        mode_i   = ~mode_i;
        thresh_i = ~thresh_i;
        if (extra_start) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        if (stall) begin
            repeat (50) @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (reqs != FD || pops != 0) begin
                n_fail++;
                $display("FAIL %s stall_credit: got reqs=%0d pops=%0d, expected reqs=%0d pops=0", nm, reqs, pops, FD);
            end
            rdy_mode = 1;
        end
        for (int i = 0; i < 3000 && done_cnt == base_done; i++) @(posedge clk);
        n_cmp++;
        if (done_cnt == base_done) begin
            n_fail++;
            $display("FAIL %s done_timeout: got no done, expected done within 3000 cycles", nm);
        end
        repeat (4) @(negedge clk);
        bad_beat = -1;

        n_cmp++;
        if (q_addr.size() != NP) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d, expected %0d", nm, q_addr.size(), NP);
        end
        exp_feat = 0;
        for (int i = 0; i < NP; i++) begin
            e[7:0]  = 8'(exp_lane(int'(pl[0][i]), int'(pl[1][i]), m));
            e[15:8] = 8'(exp_lane(int'(pl[1][i]), int'(pl[2][i]), m));
            if (iabs(int'(pl[0][i]) - int'(pl[1][i])) >= thr || iabs(int'(pl[1][i]) - int'(pl[2][i])) >= thr)
                exp_feat++;
            if (i < q_addr.size()) begin
                n_cmp++;
                if (q_addr[i] !== 16'(i) || q_dat[i] !== e) begin
                    n_fail++;
                    $display("FAIL %s beat[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                             nm, i, q_addr[i], q_dat[i], i, e);
                end
            end
        end
        n_cmp++;
        if (feat_cnt_o !== 17'(exp_feat)) begin
            n_fail++;
            $display("FAIL %s feat_cnt: got %0d, expected %0d", nm, feat_cnt_o, exp_feat);
        end
        n_cmp++;
        if (done_cnt - base_done != 1 || done_cyc != last_hs + 1) begin
            n_fail++;
            $display("FAIL %s done_pulse: got %0d pulses at cycle %0d, expected 1 pulse at cycle %0d",
                     nm, done_cnt - base_done, done_cyc, last_hs + 1);
        end
        n_cmp++;
        if (busy_o !== 1'b0 || wr_valid_o !== 1'b0 || max_out > FD) begin
            n_fail++;
            $display("FAIL %s idle_after: got busy=%b wr_valid=%b max_outstanding=%0d, expected 0 0 <=%0d",
                     nm, busy_o, wr_valid_o, max_out, FD);
        end
        n_cmp++;
        if (err_o !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b, expected %b", nm, err_o, exp_err);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rd_valid_o, rd_addr_o, wr_valid_o, wr_addr_o, wr_data_o, feat_cnt_o, busy_o, err_o, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdv=%b rda=%0d wrv=%b wra=%0d wrd=%h feat=%0d busy=%b err=%b done=%b, expected all 0",
                     rd_valid_o, rd_addr_o, wr_valid_o, wr_addr_o, wr_data_o, feat_cnt_o, busy_o, err_o, done);
        end
        n_cmp++;
        if ({b_rd_valid_o, b_wr_valid_o, b_busy_o, b_err_o, b_done, b_feat_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_b: got nonzero status %b, expected 0",
                     {b_rd_valid_o, b_wr_valid_o, b_busy_o, b_err_o, b_done, b_feat_cnt_o});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        fill_const(200, 150, 40);
        run_frame("basic", 0, 100, 2, 1, 1'b0, -1, 1'b0, 1'b0);
        n_cmp++;
        if (q_dat.size() == 0 || q_dat[0] !== 16'h6E32 || feat_cnt_o !== 17'd16) begin
            n_fail++;
            $display("FAIL basic_const: got data0=%h feat=%0d, expected 6e32 16",
                     (q_dat.size() != 0) ? q_dat[0] : 16'hxxxx, feat_cnt_o);
        end
    endtask

    task automatic test_modes();
        fill_const(255, 0, 255);
        run_frame("mode1", 1, 200, 1, 1, 1'b0, -1, 1'b0, 1'b0);
        n_cmp++;
        if (q_dat.size() == 0 || q_dat[0] !== 16'h807F) begin
            n_fail++;
            $display("FAIL mode1_sat: got %h, expected 807f", (q_dat.size() != 0) ? q_dat[0] : 16'hxxxx);
        end
        run_frame("mode2", 2, 0, 3, 1, 1'b0, -1, 1'b0, 1'b0);
        n_cmp++;
        if (q_dat.size() == 0 || q_dat[0] !== 16'h00FF) begin
            n_fail++;
            $display("FAIL mode2_clamp: got %h, expected 00ff", (q_dat.size() != 0) ? q_dat[0] : 16'hxxxx);
        end
        run_frame("mode3", 3, 255, 2, 1, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            fill_rand();
            run_frame("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                      int'($urandom_range(1, 6)), 2, 1'b0, -1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_stall();
        fill_rand();
        run_frame("stall", 0, 64, 5, 1, 1'b1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_err();
        fill_rand();
        run_frame("err_beat", 1, 30, 2, 2, 1'b0, 4, 1'b0, 1'b1);
        fill_rand();
        run_frame("err_clear", 0, 10, 3, 1, 1'b0, -1, 1'b0, 1'b0);
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_beat_err: got err=%b busy=%b, expected err=1 busy=0", err_o, busy_o);
        end
        run_frame("idle_beat_clear", 2, 5, 1, 2, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back_start();
        fill_rand();
        run_frame("start_in_run", 0, 50, 2, 1, 1'b0, -1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int base;
        fill_rand();
        mode_i = 2'd0; thresh_i = 8'd0; lat = 3; rdy_mode = 1;
        pulse_start();
        repeat (8) @(posedge clk);
        base = done_cnt;
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rd_valid_o, rd_addr_o, wr_valid_o, wr_addr_o, wr_data_o, feat_cnt_o, busy_o, err_o, done} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rdv=%b rda=%0d wrv=%b wra=%0d feat=%0d busy=%b, expected all 0",
                     rd_valid_o, rd_addr_o, wr_valid_o, wr_addr_o, feat_cnt_o, busy_o);
        end
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (done_cnt != base || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_nodone: got %0d done pulses busy=%b, expected 0 pulses busy=0", done_cnt - base, busy_o);
        end
        fill_rand();
        run_frame("after_reset", 0, 90, 4, 2, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_npix1();
        int base;
        for (int f = 0; f < 3; f++) begin
            b_p0 = 8'($urandom_range(0, 255));
            b_p1 = 8'($urandom_range(0, 255));
            b_writes = 0;
            base = b_done_cnt;
            @(posedge clk); #1 b_start = 1'b1;
            @(posedge clk); #1 b_start = 1'b0;
            for (int i = 0; i < 300 && b_done_cnt == base; i++) @(posedge clk);
            repeat (6) @(negedge clk);
            n_cmp++;
            if (b_writes != 1 || b_last_addr !== 4'd0 || b_last_dat !== 8'(exp_lane(int'(b_p0), int'(b_p1), 0))) begin
                n_fail++;
                $display("FAIL npix1_write: got writes=%0d addr=%0d data=%0d, expected 1 0 %0d",
                         b_writes, b_last_addr, b_last_dat, exp_lane(int'(b_p0), int'(b_p1), 0));
            end
            n_cmp++;
            if (b_done_cnt - base != 1 || b_feat_cnt_o !== 5'd1 || b_busy_o !== 1'b0 || b_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL npix1_done: got pulses=%0d feat=%0d busy=%b err=%b, expected 1 1 0 0",
                         b_done_cnt - base, b_feat_cnt_o, b_busy_o, b_err_o);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_random();
        test_stall();
        test_err();
        test_back_to_back_start();
        test_reset_mid();
        test_npix1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
